hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Producer side of the ID/EX pipeline-register control interface: generates stall, stall2,
//  forwarding selects FA/FB (latched into EX by ID/EX), and IF/ID flush. Sits beside decode.
//  Detects load-use hazards and branch redirects. Sequences multi-cycle mul/div occupancy
//  with an FSM and down-counter. Keeps a stall-cycle performance counter.
// PARAMETERS
//  MD_LATENCY  4   cycles stall2 is held after a mul/div enters EX (legal range 1..15)
//  CNT_W       32  width of stall_count
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low reset
//  ID_rs, ID_rt   in   5      source register numbers of the instruction in ID
//  ID_use_rs/rt   in   1      ID instruction actually reads rs / rt
//  EX_WriteReg    in   5      destination register of the instruction in EX
//  EX_RegWrite    in   1      EX instruction writes the register file
//  EX_MemtoReg    in   1      EX instruction is a load
//  EX_is_muldiv   in   1      EX instruction is mul/div
//  MEM_WriteReg   in   5      destination register of the instruction in MEM
//  MEM_RegWrite   in   1      MEM instruction writes the register file
//  EX_branch_taken in  1      branch/jump resolved taken in EX
//  stall          out  1      load-use bubble: hold PC and IF/ID, zero ID/EX
//  stall2         out  1      mul/div busy: hold PC and IF/ID, zero ID/EX
//  flush          out  1      squash IF/ID contents (taken branch)
//  FA, FB         out  2      forward select for rs/rt: 0 regfile, 1 EX/MEM, 2 MEM/WB
//  md_busy        out  1      FSM is in MD_BUSY
//  stall_count    out  CNT_W  cycles with stall|stall2 since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset low (async): state=IDLE, md_cnt=0, stall_count=0. All outputs are 0 while reset is low.
//  - Hit rules (rs shown; rt/FB are identical):
//    hitEX = ID_use_rs & EX_RegWrite & EX_WriteReg!=0 & EX_WriteReg==ID_rs.
//    hitMEM = the same test with MEM_* signals.
//  - FA = hitEX ? 1 : hitMEM ? 2 : 0. The nearer producer wins. Register $0 never forwards.
//  - stall = (hitEX_rs|hitEX_rt) & EX_MemtoReg & ~flush & state==IDLE. Mealy, same cycle.
//    Exactly one bubble per load-use hazard. On the next cycle the load is in MEM and FA/FB=2.
//  - While stall=1, FA/FB are still driven; ID/EX zeroes them.
//  - flush = EX_branch_taken. It overrides stall: a squashed ID instruction never stalls.
//  - FSM states:
//    IDLE: if EX_is_muldiv then md_cnt<=MD_LATENCY-1, go MD_BUSY.
//    MD_BUSY: stall2=1, md_busy=1. If md_cnt==0 go IDLE, else md_cnt<=md_cnt-1.
//    stall2 is high for exactly MD_LATENCY consecutive cycles, starting the cycle after the
//    mul/div is seen in EX.
//  - EX_is_muldiv during MD_BUSY is ignored; EX holds a bubble then.
//  - In MD_BUSY, stall is forced 0 (stall2 already bubbles). flush may still assert.
//  - stall_count increments every cycle that stall|stall2 is 1. It wraps from all-ones to 0.
//  - Reset asserted mid MD_BUSY: the FSM aborts to IDLE immediately. No residual stall2.
// STRUCTURE
//  - Shared pipeline package holds FWD_REG=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2,
//    state encodings IDLE/MD_BUSY, and REG_ZERO=5'd0.
//  - Sub-module fwd_select: pure compare logic, instantiated twice (rs->FA, rt->FB).
//    The FSM, md_cnt and stall_count live in the top.
// TESTING
//  - EX: lw $8 (RegWrite=1, MemtoReg=1); ID: add $9,$8,$1 -> stall=1 for exactly 1 cycle.
//    Next cycle MEM_WriteReg=8 gives FA=2, stall=0.
//  - EX writes $5 (ALU op); MEM also writes $5; ID reads rs=$5 -> FA=1 (EX wins). rt=$3 unmatched -> FB=0.
//  - EX_WriteReg=0 with RegWrite=1, ID_rs=0 -> FA=0 and stall=0.
//  - EX_is_muldiv pulse with MD_LATENCY=4 -> stall2 high 4 cycles. md_busy matches stall2.
//    stall_count advances by 4.
//  - Load-use hazard and EX_branch_taken in the same cycle -> flush=1, stall=0.
//  - Reset pulsed low in the 2nd cycle of MD_BUSY -> stall2=0 immediately, state IDLE,
//    stall_count=0 after release.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// rtl/hazard_ctrl_unit_pkg.sv - shared pipeline constants for the hazard control unit
package hazard_ctrl_unit_pkg;
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;
endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// rtl/hazard_ctrl_unit_fwd_select.sv - per-operand forward select; nearer producer wins, $0 never forwards
module hazard_ctrl_unit_fwd_select
  import hazard_ctrl_unit_pkg::*;
(
  input  logic [4:0] id_reg_i,
  input  logic       id_use_i,
  input  logic [4:0] ex_write_reg_i,
  input  logic       ex_reg_write_i,
  input  logic [4:0] mem_write_reg_i,
  input  logic       mem_reg_write_i,
  output logic [1:0] fwd_sel_o,
  output logic       hit_ex_o
);
  logic hit_mem;

  assign hit_ex_o = id_use_i & ex_reg_write_i & (ex_write_reg_i != REG_ZERO)
                    & (ex_write_reg_i == id_reg_i);
  assign hit_mem  = id_use_i & mem_reg_write_i & (mem_write_reg_i != REG_ZERO)
                    & (mem_write_reg_i == id_reg_i);

  assign fwd_sel_o = hit_ex_o ? FWD_EXMEM : (hit_mem ? FWD_MEMWB : FWD_REG);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use stall, mul/div occupancy stall2, branch flush and forwarding selects
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [4:0]       ex_write_reg_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_memto_reg_i,
  input  logic             ex_is_muldiv_i,
  input  logic [4:0]       mem_write_reg_i,
  input  logic             mem_reg_write_i,
  input  logic             ex_branch_taken_i,
  output logic             stall_o,
  output logic             stall2_o,
  output logic             flush_o,
  output logic [1:0]       fa_o,
  output logic [1:0]       fb_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_count_o
);
  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 1);

  md_state_e        state_q;
  logic [3:0]       md_cnt_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [1:0]       fa_raw, fb_raw;
  logic             hit_ex_rs, hit_ex_rt;
  logic             stall_raw, busy;

  hazard_ctrl_unit_fwd_select u_fwd_rs (
    .id_reg_i       (id_rs_i),
    .id_use_i       (id_use_rs_i),
    .ex_write_reg_i (ex_write_reg_i),
    .ex_reg_write_i (ex_reg_write_i),
    .mem_write_reg_i(mem_write_reg_i),
    .mem_reg_write_i(mem_reg_write_i),
    .fwd_sel_o      (fa_raw),
    .hit_ex_o       (hit_ex_rs)
  );

  hazard_ctrl_unit_fwd_select u_fwd_rt (
    .id_reg_i       (id_rt_i),
    .id_use_i       (id_use_rt_i),
    .ex_write_reg_i (ex_write_reg_i),
    .ex_reg_write_i (ex_reg_write_i),
    .mem_write_reg_i(mem_write_reg_i),
    .mem_reg_write_i(mem_reg_write_i),
    .fwd_sel_o      (fb_raw),
    .hit_ex_o       (hit_ex_rt)
  );

  assign busy      = (state_q == MD_BUSY);
  // A squashed ID instruction never stalls, and mul/div occupancy already bubbles.
  assign stall_raw = (hit_ex_rs | hit_ex_rt) & ex_memto_reg_i & ~ex_branch_taken_i & ~busy;

  // Combinational outputs are forced low while reset is held.
  assign stall_o   = stall_raw & reset_i;
  assign flush_o   = ex_branch_taken_i & reset_i;
  assign fa_o      = reset_i ? fa_raw : FWD_REG;
  assign fb_o      = reset_i ? fb_raw : FWD_REG;
  assign stall2_o  = busy;
  assign md_busy_o = busy;
  assign stall_count_o = stall_count_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      md_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_is_muldiv_i) begin
            md_cnt_q <= MD_INIT;
            state_q  <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (md_cnt_q == 4'd0) state_q <= IDLE;
          else                  md_cnt_q <= md_cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_raw | busy) stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) stall_count_q <= '0;
    else          stall_count_q <= stall_count_d;
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
  logic        clk, reset_n;
  logic [4:0]  id_rs, id_rt, ex_write, mem_write;
  logic        use_rs, use_rt, ex_rw, ex_m2r, ex_md, mem_rw, br;
  logic        stall, stall2, flush, md_busy;
  logic [1:0]  fa, fb;
  logic [31:0] cnt;

  typedef struct packed {
    logic        stall;
    logic        stall2;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        md_busy;
    logic [31:0] cnt;
  } obs_t;

  obs_t  sb_q[$];
  string tag_q[$];
  int    n_cmp, n_bad;
  logic [31:0] exp_cnt;

  hazard_ctrl_unit #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .clock_i          (clk),
    .reset_i          (reset_n),
    .id_rs_i          (id_rs),
    .id_rt_i          (id_rt),
    .id_use_rs_i      (use_rs),
    .id_use_rt_i      (use_rt),
    .ex_write_reg_i   (ex_write),
    .ex_reg_write_i   (ex_rw),
    .ex_memto_reg_i   (ex_m2r),
    .ex_is_muldiv_i   (ex_md),
    .mem_write_reg_i  (mem_write),
    .mem_reg_write_i  (mem_rw),
    .ex_branch_taken_i(br),
    .stall_o          (stall),
    .stall2_o         (stall2),
    .flush_o          (flush),
    .fa_o             (fa),
    .fb_o             (fb),
    .md_busy_o        (md_busy),
    .stall_count_o    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_in();
    id_rs = 0; id_rt = 0; use_rs = 0; use_rt = 0;
    ex_write = 0; ex_rw = 0; ex_m2r = 0; ex_md = 0;
    mem_write = 0; mem_rw = 0; br = 0;
  endtask

  // md_busy is expected to track stall2; the counter expectation is taken
  // before this cycle's stall contributes to it.
  task automatic expect_out(input string tag, input logic st, input logic st2,
                            input logic fl, input logic [1:0] efa, input logic [1:0] efb);
    obs_t e;
    e = {st, st2, fl, efa, efb, st2, exp_cnt};
    sb_q.push_back(e);
    tag_q.push_back(tag);
    exp_cnt = exp_cnt + 32'(st | st2);
  endtask

  task automatic compare();
    obs_t o, e;
    string t;
    o = {stall, stall2, flush, fa, fb, md_busy, cnt};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty observed=%h expected=<entry>", o);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s observed={st,st2,fl,fa,fb,busy,cnt}=%h expected=%h", t, o, e);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_cnt = 0;
    reset_n = 1'b0;
    idle_in();
    ex_write = 8; ex_rw = 1; ex_m2r = 1; id_rs = 8; use_rs = 1;
    id_rt = 8; use_rt = 1; mem_write = 8; mem_rw = 1; br = 1; ex_md = 1;
    #2;
    expect_out("reset_outputs_low", 0, 0, 0, 0, 0);
    #1 compare();
    expect_out("reset_held_over_edge", 0, 0, 0, 0, 0);
    sample();

    next_cycle(); reset_n = 1'b1; idle_in();
    ex_write = 8; ex_rw = 1; ex_m2r = 1; id_rs = 8; use_rs = 1; id_rt = 1; use_rt = 1;
    expect_out("load_use_stall", 1, 0, 0, 1, 0);
    sample();

    next_cycle(); idle_in();
    mem_write = 8; mem_rw = 1; id_rs = 8; use_rs = 1; id_rt = 1; use_rt = 1;
    expect_out("load_in_mem_fwd2", 0, 0, 0, 2, 0);
    sample();

    next_cycle(); idle_in();
    ex_write = 5; ex_rw = 1; mem_write = 5; mem_rw = 1;
    id_rs = 5; use_rs = 1; id_rt = 3; use_rt = 1;
    expect_out("ex_wins_over_mem", 0, 0, 0, 1, 0);
    sample();

    next_cycle(); idle_in();
    ex_write = 5; ex_rw = 1; mem_write = 7; mem_rw = 1;
    id_rs = 7; use_rs = 1; id_rt = 5; use_rt = 1;
    expect_out("fa_mem_fb_ex", 0, 0, 0, 2, 1);
    sample();

    next_cycle(); idle_in();
    ex_write = 0; ex_rw = 1; ex_m2r = 1; mem_write = 0; mem_rw = 1;
    id_rs = 0; use_rs = 1; id_rt = 0; use_rt = 1;
    expect_out("reg_zero_never_fwd", 0, 0, 0, 0, 0);
    sample();

    next_cycle(); idle_in();
    ex_write = 6; ex_rw = 1; ex_m2r = 1; id_rs = 6; use_rs = 0; id_rt = 2; use_rt = 1;
    expect_out("unused_rs_no_hazard", 0, 0, 0, 0, 0);
    sample();

    next_cycle(); idle_in();
    ex_write = 8; ex_rw = 1; ex_m2r = 1; id_rs = 8; use_rs = 1; br = 1;
    expect_out("flush_overrides_stall", 0, 0, 1, 1, 0);
    sample();

    next_cycle(); idle_in(); ex_md = 1;
    expect_out("muldiv_enters_ex", 0, 0, 0, 0, 0);
    sample();
    next_cycle(); idle_in();
    expect_out("md_busy_1", 0, 1, 0, 0, 0);
    sample();
    next_cycle(); idle_in(); ex_md = 1;
    expect_out("md_busy_2_muldiv_ignored", 0, 1, 0, 0, 0);
    sample();
    next_cycle(); idle_in();
    ex_write = 8; ex_rw = 1; ex_m2r = 1; id_rs = 8; use_rs = 1;
    expect_out("md_busy_3_stall_forced0", 0, 1, 0, 1, 0);
    sample();
    next_cycle(); idle_in(); br = 1;
    expect_out("md_busy_4_flush", 0, 1, 1, 0, 0);
    sample();
    next_cycle(); idle_in();
    expect_out("md_done_count_plus4", 0, 0, 0, 0, 0);
    sample();

    next_cycle(); idle_in(); ex_md = 1;
    expect_out("muldiv_again", 0, 0, 0, 0, 0);
    sample();
    next_cycle(); idle_in();
    expect_out("md_busy_before_reset", 0, 1, 0, 0, 0);
    sample();
    next_cycle(); #1;
    reset_n = 1'b0; exp_cnt = 0;
    expect_out("reset_aborts_md_busy", 0, 0, 0, 0, 0);
    #1 compare();
    next_cycle(); reset_n = 1'b1;
    expect_out("no_residual_stall2", 0, 0, 0, 0, 0);
    sample();
    next_cycle(); idle_in();
    ex_write = 12; ex_rw = 1; ex_m2r = 1; id_rt = 12; use_rt = 1;
    expect_out("load_use_rt_after_reset", 1, 0, 0, 0, 1);
    sample();
    next_cycle(); idle_in();
    expect_out("count_after_rt_stall", 0, 0, 0, 0, 0);
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
